time_uart_reporter: RTL
=======================

// Module: time_uart_reporter
// PURPOSE
//  Consumes the selected time (data_hour/data_min/data_sec) from the stopwatch/watch top.
//  On a trigger pulse it snapshots that time and formats it as ASCII "HH:MM:SS" (+CR LF).
//  It streams the message one byte at a time into the UART TX stage over a start/done handshake.
//  Typical trigger: the UART RX command decoder or a debounced button.
// PARAMETERS
//  SEND_CRLF  1      1: append 8'h0D,8'h0A (10-byte message); 0: 8-byte message
//  SEP_CHAR   8'h3A  separator byte between fields (':')
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-high reset
//  i_trig     in   1  1-cycle request to send the current time
//  i_sec      in   6  seconds, binary 0..59
//  i_min      in   6  minutes, binary 0..59
//  i_hour     in   5  hours, binary 0..23
//  i_tx_done  in   1  1-cycle pulse from UART TX: previous byte fully shifted out
//  o_tx_start out  1  1-cycle pulse: o_tx_data is valid, UART TX must start
//  o_tx_data  out  8  byte to transmit; held stable from o_tx_start until i_tx_done
//  o_busy     out  1  high from snapshot until the last byte's i_tx_done
// BEHAVIOUR
//  Reset: o_tx_start=0, o_tx_data=8'h00, o_busy=0, state=IDLE, byte index=0, snapshot=0.
//   Applies in any state; an in-flight message is abandoned and no further start is issued.
//  FSM states:
//   IDLE: wait for i_trig. On i_trig, register i_hour/i_min/i_sec -> LOAD and set o_busy=1.
//   LOAD: select byte[idx] into o_tx_data, pulse o_tx_start for 1 cycle -> WAIT.
//   WAIT: on i_tx_done, idx+1. If idx was last -> IDLE, o_busy=0; else -> LOAD.
//  Latency: i_trig in cycle N -> o_busy=1 and LOAD in N+1 -> o_tx_start in N+1.
//   Next start is issued 1 cycle after each i_tx_done.
//  Byte order, idx 0..9:
//   H1 H0 SEP M1 M0 SEP S1 S0, then CR LF when SEND_CRLF=1.
//  Digit encoding: tens = v/10, ones = v%10, each byte = 8'h30 + digit. Use constant compare/subtract.
//   No divider is allowed.
//  Out-of-range inputs are not clamped; 63 encodes as "63".
//  Width rule: a 5-bit hour is zero-extended to 6 bits before encoding.
//  The snapshot is frozen for the whole message.
//   Input changes during a send (including rollover 23:59:59 -> 00:00:00) never mix into it.
//  i_trig while o_busy=1 is ignored; it is not queued.
//  i_trig in the same cycle as the final i_tx_done is also ignored, because state is not yet IDLE.
//  i_tx_done outside WAIT is ignored.
//  i_tx_done in the same cycle as o_tx_start is ignored; only the WAIT state accepts it.
// STRUCTURE
//  Shared package: state encoding (IDLE/LOAD/WAIT) and the ASCII constants.
//   Constants: ASCII_0=8'h30, ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_COLON=8'h3A.
//  One sub-module: bin2ascii2. It is combinational, maps 6-bit binary to {tens_ascii, ones_ascii},
//   and has 3 instances (hour, min, sec).
//  Byte mux, index counter and FSM live in time_uart_reporter.
// TESTING
//  1. Hold 12:34:56, SEND_CRLF=1, trig, auto-ack each start after 5 cycles.
//     -> bytes 31 32 3A 33 34 3A 35 36 0D 0A; o_busy drops after the 10th done.
//  2. Value 00:00:00 with SEND_CRLF=0.
//     -> exactly 8 starts: 30 30 3A 30 30 3A 30 30; no CR/LF.
//  3. Send 23:59:59, change inputs to 00:00:00 after byte 2.
//     -> full message still reads 23:59:59.
//  4. Pulse i_trig at byte 4 and again on the final i_tx_done cycle.
//     -> exactly one message; o_busy=0 afterwards; no extra start.
//  5. Assert reset during WAIT of byte 5.
//     -> next cycle o_busy=0, o_tx_data=00, no o_tx_start. A new trig restarts at byte 0 ('H1').
//  6. Spurious i_tx_done in IDLE, then trig with 09:05:07.
//     -> no effect before trig; bytes 30 39 3A 30 35 3A 30 37.

Source files
------------

// File: rtl/time_uart_reporter_pkg.sv
// Shared constants for the time-of-day UART reporter.
// State encoding and ASCII bytes used by the formatter.
package time_uart_reporter_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;

endpackage

// File: rtl/time_uart_reporter_bin2ascii2.sv
// Two-digit binary-to-ASCII converter for values 0..63.
// Tens found by constant compare/subtract, no divider.
module bin2ascii2
    import time_uart_reporter_pkg::*;
(
    input  logic [5:0] value,
    output logic [7:0] tens_ascii,
    output logic [7:0] ones_ascii
);

    logic [2:0] tens;
    logic [5:0] rem;

    // Pick the largest multiple of ten not above the value
    always_comb begin
        tens = 3'd0;
        rem  = value;
        if (value >= 6'd60) begin
            tens = 3'd6;
            rem  = value - 6'd60;
        end else if (value >= 6'd50) begin
            tens = 3'd5;
            rem  = value - 6'd50;
        end else if (value >= 6'd40) begin
            tens = 3'd4;
            rem  = value - 6'd40;
        end else if (value >= 6'd30) begin
            tens = 3'd3;
            rem  = value - 6'd30;
        end else if (value >= 6'd20) begin
            tens = 3'd2;
            rem  = value - 6'd20;
        end else if (value >= 6'd10) begin
            tens = 3'd1;
            rem  = value - 6'd10;
        end
    end

    assign tens_ascii = ASCII_0 + {5'd0, tens};
    assign ones_ascii = ASCII_0 + {2'd0, rem};

endmodule

// File: rtl/time_uart_reporter.sv
// Snapshots hour/min/sec on a trigger and streams "HH:MM:SS"
// (optionally CR LF) to a UART TX over a start/done handshake.
module time_uart_reporter
    import time_uart_reporter_pkg::*;
#(
    parameter bit         SEND_CRLF = 1'b1,
    parameter logic [7:0] SEP_CHAR  = 8'h3A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_trig,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [4:0] i_hour,
    input  logic       i_tx_done,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    output logic       o_busy
);

    localparam logic [3:0] LAST_IDX = SEND_CRLF ? 4'd9 : 4'd7;

    logic [1:0] state;
    logic [3:0] idx;
    logic [4:0] snap_hour;
    logic [5:0] snap_min;
    logic [5:0] snap_sec;
    logic [7:0] h1, h0, m1, m0, s1, s0;
    logic [7:0] byte_sel;

    bin2ascii2 u_hour (
        .value      ({1'b0, snap_hour}),
        .tens_ascii (h1),
        .ones_ascii (h0)
    );

    bin2ascii2 u_min (
        .value      (snap_min),
        .tens_ascii (m1),
        .ones_ascii (m0)
    );

    bin2ascii2 u_sec (
        .value      (snap_sec),
        .tens_ascii (s1),
        .ones_ascii (s0)
    );

    // Select the message byte addressed by the index counter
    always_comb begin
        byte_sel = 8'h00;
        unique case (idx)
            4'd0:    byte_sel = h1;
            4'd1:    byte_sel = h0;
            4'd2:    byte_sel = SEP_CHAR;
            4'd3:    byte_sel = m1;
            4'd4:    byte_sel = m0;
            4'd5:    byte_sel = SEP_CHAR;
            4'd6:    byte_sel = s1;
            4'd7:    byte_sel = s0;
            4'd8:    byte_sel = ASCII_CR;
            4'd9:    byte_sel = ASCII_LF;
            default: byte_sel = 8'h00;
        endcase
    end

    // Sequencer: snapshot on trigger, then one byte per done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= 4'd0;
            snap_hour <= 5'd0;
            snap_min  <= 6'd0;
            snap_sec  <= 6'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_trig) begin
                        snap_hour <= i_hour;
                        snap_min  <= i_min;
                        snap_sec  <= i_sec;
                        idx       <= 4'd0;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: state <= S_WAIT;
                S_WAIT: begin
                    if (i_tx_done) begin
                        if (idx == LAST_IDX) begin
                            idx   <= 4'd0;
                            state <= S_IDLE;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= S_LOAD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_tx_start = (state == S_LOAD);
    assign o_busy     = (state != S_IDLE);
    assign o_tx_data  = (state == S_IDLE) ? 8'h00 : byte_sel;

endmodule
